// File: rtl/readcode_burst_responder_if.sv
// readcode_burst_responder_if: readcode link plus Avalon-MM burst-read signals
//   readcode side : readcode_do/address in, readcode_done/line/partial/partial_done out
//   avalon side   : avm_address/read/burstcount out, avm_waitrequest/readdata/readdatavalid in
//   slave modport is the responder's view, master modport is the mirror (requester + memory)
interface readcode_burst_responder_if;
  logic         readcode_do;
  logic         readcode_done;
  logic [31:0]  readcode_address;
  logic [127:0] readcode_line;
  logic [31:0]  readcode_partial;
  logic         readcode_partial_done;
  logic [31:0]  avm_address;
  logic         avm_read;
  logic [2:0]   avm_burstcount;
  logic         avm_waitrequest;
  logic [31:0]  avm_readdata;
  logic         avm_readdatavalid;
  modport slave (
    input  readcode_do, readcode_address, avm_waitrequest, avm_readdata, avm_readdatavalid,
    output readcode_done, readcode_line, readcode_partial, readcode_partial_done,
           avm_address, avm_read, avm_burstcount
  );
  modport master (
    output readcode_do, readcode_address, avm_waitrequest, avm_readdata, avm_readdatavalid,
    input  readcode_done, readcode_line, readcode_partial, readcode_partial_done,
           avm_address, avm_read, avm_burstcount
  );
endinterface

// File: rtl/readcode_burst_responder.sv
// readcode_burst_responder: fetches a 16-byte line as one 4-beat Avalon burst and returns it
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   bus   : readcode link + Avalon-MM master signals (slave modport)
//   PARTIAL_ENABLE : 1 pulses readcode_partial_done per beat, 0 keeps it low
module readcode_burst_responder #(
  parameter bit PARTIAL_ENABLE = 1'b1
) (
  input logic                         clk,
  input logic                         rst_n,
  readcode_burst_responder_if.slave   bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] DATA = 2'd2;
  localparam logic [1:0] DONE = 2'd3;
  logic [1:0]   state_q, state_d, cnt_q;
  logic [31:0]  addr_q, partial_q;
  logic [127:0] line_q;
  logic         read_q, pdone_q, done_q, beat;
  // beats are only honoured in DATA; strays in other states are dropped
  assign beat = state_q == DATA && bus.avm_readdatavalid;
  always_comb
    state_d = state_q == IDLE ? (bus.readcode_do ? REQ : IDLE) :
              state_q == REQ  ? (bus.avm_waitrequest ? REQ : DATA) :
              state_q == DATA ? ((beat && cnt_q == 2'd3) ? DONE : DATA) : IDLE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      partial_q <= '0;
      line_q    <= '0;
      read_q    <= 1'b0;
      pdone_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      read_q  <= state_d == REQ;
      pdone_q <= PARTIAL_ENABLE && beat;
      done_q  <= beat && cnt_q == 2'd3;
      if (state_q == IDLE && bus.readcode_do) begin
        addr_q <= {bus.readcode_address[31:4], 4'b0};
        cnt_q  <= '0;
      end
      if (beat) begin
        line_q[{cnt_q, 5'd0} +: 32] <= bus.avm_readdata;
        partial_q                   <= bus.avm_readdata;
        cnt_q                       <= cnt_q + 2'd1;
      end
    end
  assign bus.avm_address           = addr_q;
  assign bus.avm_read              = read_q;
  assign bus.avm_burstcount        = read_q ? 3'd4 : 3'd0;
  assign bus.readcode_done         = done_q;
  assign bus.readcode_line         = line_q;
  assign bus.readcode_partial      = partial_q;
  assign bus.readcode_partial_done = pdone_q;
endmodule

// File: tb/tb_readcode_burst_responder.sv
// tb_readcode_burst_responder: directed bench with a partial/line scoreboard, both PARTIAL_ENABLE settings
module tb_readcode_burst_responder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  readcode_burst_responder_if b0 ();
  readcode_burst_responder_if b1 ();
  assign b1.readcode_do       = b0.readcode_do;
  assign b1.readcode_address  = b0.readcode_address;
  assign b1.avm_waitrequest   = b0.avm_waitrequest;
  assign b1.avm_readdata      = b0.avm_readdata;
  assign b1.avm_readdatavalid = b0.avm_readdatavalid;
  readcode_burst_responder #(.PARTIAL_ENABLE(1'b1)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));
  readcode_burst_responder #(.PARTIAL_ENABLE(1'b0)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
  int ncmp = 0;
  int nerr = 0;
  logic [31:0]  pq[$];
  logic [127:0] lq[$];
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    ncmp++;
    if (obs !== exp) begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk)
    if (rst_n) begin
      if (b0.readcode_partial_done) begin
        if (pq.size() == 0) chk("pdone_unexpected", b0.readcode_partial_done, 1'b0);
        else begin
          logic [31:0] e;
          e = pq.pop_front();
          chk("partial", b0.readcode_partial, e);
          chk("pe0_partial", b1.readcode_partial, e);
        end
      end
      if (b1.readcode_partial_done) chk("pe0_pdone", b1.readcode_partial_done, 1'b0);
      if (b0.readcode_done) begin
        if (lq.size() == 0) chk("done_unexpected", b0.readcode_done, 1'b0);
        else begin
          logic [127:0] e;
          e = lq.pop_front();
          chk("line", b0.readcode_line, e);
          chk("pe0_line", b1.readcode_line, e);
          chk("pe0_done", b1.readcode_done, 1'b1);
        end
      end
    end
  task automatic check_zero(input string tag);
    chk({tag, "_read"}, b0.avm_read, 1'b0);
    chk({tag, "_addr"}, b0.avm_address, 32'h0);
    chk({tag, "_burst"}, b0.avm_burstcount, 3'd0);
    chk({tag, "_done"}, b0.readcode_done, 1'b0);
    chk({tag, "_pdone"}, b0.readcode_partial_done, 1'b0);
    chk({tag, "_partial"}, b0.readcode_partial, 32'h0);
    chk({tag, "_line"}, b0.readcode_line, 128'h0);
  endtask
  task automatic fetch(input logic [31:0] addr, input logic [31:0] exp_a, input int waits,
                       input int n, input logic [15:0] mask,
                       input logic [31:0] w0, input logic [31:0] w1,
                       input logic [31:0] w2, input logic [31:0] w3);
    logic [31:0] w[4];
    int k;
    w = '{w0, w1, w2, w3};
    k = 0;
    b0.readcode_do = 1'b1;
    b0.readcode_address = addr;
    step();
    chk("req_read", b0.avm_read, 1'b1);
    chk("req_addr", b0.avm_address, exp_a);
    chk("req_burst", b0.avm_burstcount, 3'd4);
    b0.readcode_address = 32'hdead_beef;
    b0.avm_waitrequest = 1'b1;
    for (int i = 0; i < waits; i++) begin
      b0.avm_readdatavalid = 1'b1;
      b0.avm_readdata = 32'hbad0_0000 + i;
      step();
      chk("hold_read", b0.avm_read, 1'b1);
      chk("hold_addr", b0.avm_address, exp_a);
    end
    b0.avm_readdatavalid = 1'b0;
    b0.avm_waitrequest = 1'b0;
    step();
    chk("acc_read", b0.avm_read, 1'b0);
    chk("acc_burst", b0.avm_burstcount, 3'd0);
    for (int i = 0; i < n; i++) begin
      b0.avm_readdatavalid = mask[i];
      b0.avm_readdata = mask[i] ? w[k] : 32'hbad1_0000 + i;
      if (mask[i]) begin
        pq.push_back(w[k]);
        if (k == 3) lq.push_back({w3, w2, w1, w0});
        k++;
      end
      step();
      chk("done_time", b0.readcode_done, mask[i] && k == 4);
    end
    b0.avm_readdatavalid = 1'b0;
    step();
    chk("done_pulse", b0.readcode_done, 1'b0);
    b0.readcode_do = 1'b0;
  endtask
  initial begin
    b0.readcode_do = 1'b0;
    b0.readcode_address = '0;
    b0.avm_waitrequest = 1'b0;
    b0.avm_readdata = '0;
    b0.avm_readdatavalid = 1'b0;
    step();
    step();
    check_zero("rst");
    rst_n = 1'b1;
    step();
    fetch(32'h0000_1230, 32'h0000_1230, 0, 4, 16'h000f,
          32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444);
    fetch(32'h0001_2347, 32'h0001_2340, 3, 4, 16'h000f,
          32'ha0a0_0001, 32'hb0b0_0002, 32'hc0c0_0003, 32'hd0d0_0004);
    fetch(32'h0000_0500, 32'h0000_0500, 1, 7, 16'h0059,
          32'h0123_4567, 32'h89ab_cdef, 32'hfedc_ba98, 32'h7654_3210);
    step();
    chk("b2b_no_dup", b0.avm_read, 1'b0);
    step();
    chk("b2b_no_dup2", b0.avm_read, 1'b0);
    fetch(32'h0000_0040, 32'h0000_0040, 0, 4, 16'h000f,
          32'h5555_0000, 32'h6666_1111, 32'h7777_2222, 32'h8888_3333);
    b0.readcode_do = 1'b1;
    b0.readcode_address = 32'h0000_2000;
    step();
    b0.readcode_do = 1'b0;
    step();
    b0.avm_readdatavalid = 1'b1;
    b0.avm_readdata = 32'hcafe_0001;
    pq.push_back(32'hcafe_0001);
    step();
    b0.avm_readdata = 32'hcafe_0002;
    pq.push_back(32'hcafe_0002);
    step();
    b0.avm_readdatavalid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_zero("midrst");
    pq.delete();
    step();
    rst_n = 1'b1;
    b0.avm_readdatavalid = 1'b1;
    b0.avm_readdata = 32'hcafe_0003;
    step();
    b0.avm_readdata = 32'hcafe_0004;
    step();
    b0.avm_readdatavalid = 1'b0;
    chk("stray_pdone", b0.readcode_partial_done, 1'b0);
    chk("stray_done", b0.readcode_done, 1'b0);
    step();
    chk("stray_read", b0.avm_read, 1'b0);
    fetch(32'h0000_3008, 32'h0000_3000, 2, 4, 16'h000f,
          32'h0bad_f00d, 32'h1234_5678, 32'h9abc_def0, 32'h0f0f_f0f0);
    step();
    step();
    chk("pq_drained", pq.size(), 0);
    chk("lq_drained", lq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
